regfile_wb_stage: RTL and testbench
===================================

// Module: regfile_wb_stage
// PURPOSE
//  Writeback stage of the 16-bit pipeline; drives the write port of the 16x16 register file.
//  Holds the MEM/WB pipeline register and selects the ALU result or the memory load data.
//  Generates DstReg/DstData/WriteReg for the register file, with $0 hard-wired to zero.
//  Provides write-through bypass for both read ports, plus a sticky halt flag and a retire counter.
// PARAMETERS
//  DATA_W     16  datapath / register width
//  REG_ADDR_W 4   register specifier width (2**REG_ADDR_W registers)
// PORTS
//  clk           in  1          rising-edge clock
//  rst           in  1          synchronous, active-high reset
//  stall         in  1          hold the MEM/WB register contents
//  flush         in  1          load a bubble into MEM/WB (wins over stall)
//  in_valid      in  1          MEM stage carries a real instruction
//  in_regwrite   in  1          instruction writes a register
//  in_memtoreg   in  1          1 = writeback data from in_mem_data, 0 = from in_alu_result
//  in_halt       in  1          instruction is HLT
//  in_dst_reg    in  REG_ADDR_W destination register
//  in_alu_result in  DATA_W     ALU result
//  in_mem_data   in  DATA_W     load data
//  SrcReg1       in  REG_ADDR_W decode-stage read address, port 1
//  SrcReg2       in  REG_ADDR_W decode-stage read address, port 2
//  rf_data1      in  DATA_W     raw register-file bitline value, port 1
//  rf_data2      in  DATA_W     raw register-file bitline value, port 2
//  DstReg        out REG_ADDR_W write address to register file
//  DstData       out DATA_W     write data to register file
//  WriteReg      out 1          register-file write enable
//  bypass_data1  out DATA_W     forwarded read data, port 1
//  bypass_data2  out DATA_W     forwarded read data, port 2
//  halted        out 1          sticky: a HLT has retired
//  retire_count  out 16         count of retired instructions, saturating
// BEHAVIOUR
//  MEM/WB register update, evaluated at each clk edge in priority order:
//   - rst: wb_valid, halted and retire_count <= 0; all other fields <= 0.
//   - flush: wb_valid <= 0.
//   - halted, or wb_valid & wb_halt: wb_valid <= 0. Later input is ignored.
//   - stall: hold all fields.
//   - otherwise: capture all in_* fields.
//  Outputs are combinational from the MEM/WB register, with 1-cycle latency from in_* to WriteReg.
//  DstData = wb_memtoreg ? wb_mem_data : wb_alu_result. DstReg = wb_dst_reg.
//  WriteReg = wb_valid & wb_regwrite & ~wb_halt & (wb_dst_reg != 0). A write to $0 is never issued.
//  During stall, WriteReg stays asserted for the held instruction. The rewrite is idempotent.
//  Bypass, for each port N:
//   - SrcRegN == 0: bypass_dataN = 0.
//   - else if WriteReg & DstReg == SrcRegN: bypass_dataN = DstData.
//   - else: bypass_dataN = rf_dataN.
//  If both ports name the same register, both ports are bypassed.
//  Retire: an instruction retires on a cycle with wb_valid & ~stall & ~flush & ~halted.
//   - retire_count increments by 1 on a retire and saturates at 16'hFFFF; it never wraps.
//   - A retiring HLT is counted, and halted <= 1 at the same edge.
//  halted is cleared only by rst. While halted, WriteReg = 0.
//  rst asserted mid-operation: at the next edge the state is cleared.
//   No write to the register file occurs in the cycle after reset.
// TESTING
//  1. rst for 2 cycles -> WriteReg=0, halted=0, retire_count=0, DstReg=0, DstData=0.
//  2. in_valid=1, regwrite=1, memtoreg=0, dst=3, alu=16'h1234 ->
//     the next cycle gives WriteReg=1, DstReg=3, DstData=16'h1234;
//     with SrcReg1=3 and rf_data1=16'hBEEF, bypass_data1=16'h1234.
//  3. memtoreg=1, mem=16'hA5A5, dst=0 -> WriteReg=0;
//     SrcReg2=0 with rf_data2=16'hFFFF gives bypass_data2=0.
//  4. stall for 3 cycles with a valid write to dst=5 in WB ->
//     DstReg=5 held for 3 cycles; retire_count increments once, after stall drops.
//     flush together with stall -> WB becomes a bubble, WriteReg=0.
//  5. HLT retires after 4 ALU ops -> retire_count=5, halted=1.
//     A following valid write to dst=7 gives WriteReg=0. rst clears halted.
//  6. Force retire_count to 16'hFFFE and retire 3 instructions -> retire_count=16'hFFFF, no wrap.

Source files
------------

// File: rtl/regfile_wb_stage.sv
// regfile_wb_stage
//   Writeback stage of the 16-bit pipeline. Holds the MEM/WB pipeline
//   register, selects ALU result or load data, and drives the register-file
//   write port ($0 is never written). Also provides write-through bypass for
//   both decode read ports, a sticky halt flag and a saturating retire counter.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   stall, flush    hold MEM/WB / load a bubble into MEM/WB (flush wins)
//   in_*            MEM-stage instruction fields captured into MEM/WB
//   SrcReg1/2       decode-stage read addresses
//   rf_data1/2      raw register-file read values
//   DstReg/DstData  register-file write address / data
//   WriteReg        register-file write enable
//   bypass_data1/2  forwarded read data
//   halted          sticky, set when a HLT retires
//   retire_count    retired-instruction count, saturating at 16'hFFFF
module regfile_wb_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_regwrite,
    input  logic                  in_memtoreg,
    input  logic                  in_halt,
    input  logic [REG_ADDR_W-1:0] in_dst_reg,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_mem_data,
    input  logic [REG_ADDR_W-1:0] SrcReg1,
    input  logic [REG_ADDR_W-1:0] SrcReg2,
    input  logic [DATA_W-1:0]     rf_data1,
    input  logic [DATA_W-1:0]     rf_data2,
    output logic [REG_ADDR_W-1:0] DstReg,
    output logic [DATA_W-1:0]     DstData,
    output logic                  WriteReg,
    output logic [DATA_W-1:0]     bypass_data1,
    output logic [DATA_W-1:0]     bypass_data2,
    output logic                  halted,
    output logic [15:0]           retire_count
);

    logic                  wb_valid_q,    wb_valid_d;
    logic                  wb_regwrite_q, wb_regwrite_d;
    logic                  wb_memtoreg_q, wb_memtoreg_d;
    logic                  wb_halt_q,     wb_halt_d;
    logic [REG_ADDR_W-1:0] wb_dst_reg_q,  wb_dst_reg_d;
    logic [DATA_W-1:0]     wb_alu_q,      wb_alu_d;
    logic [DATA_W-1:0]     wb_mem_q,      wb_mem_d;
    logic                  halted_q,      halted_d;
    logic [15:0]           retire_cnt_q,  retire_cnt_d;
    logic                  retire;

    // MEM/WB next state. Flush and halt only kill the valid bit; the other
    // fields keep their previous contents.
    always_comb begin
        wb_valid_d    = wb_valid_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_memtoreg_d = wb_memtoreg_q;
        wb_halt_d     = wb_halt_q;
        wb_dst_reg_d  = wb_dst_reg_q;
        wb_alu_d      = wb_alu_q;
        wb_mem_d      = wb_mem_q;
        if (flush) begin
            wb_valid_d = 1'b0;
        end else if (halted_q || (wb_valid_q && wb_halt_q)) begin
            // Once a HLT has reached WB, nothing behind it may enter.
            wb_valid_d = 1'b0;
        end else if (!stall) begin
            wb_valid_d    = in_valid;
            wb_regwrite_d = in_regwrite;
            wb_memtoreg_d = in_memtoreg;
            wb_halt_d     = in_halt;
            wb_dst_reg_d  = in_dst_reg;
            wb_alu_d      = in_alu_result;
            wb_mem_d      = in_mem_data;
        end
    end

    assign retire = wb_valid_q & ~stall & ~flush & ~halted_q;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (retire && (retire_cnt_q != 16'hFFFF)) begin
            retire_cnt_d = retire_cnt_q + 16'd1;
        end
        halted_d = halted_q | (retire & wb_halt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_halt_q     <= 1'b0;
            wb_dst_reg_q  <= '0;
            wb_alu_q      <= '0;
            wb_mem_q      <= '0;
            halted_q      <= 1'b0;
            retire_cnt_q  <= '0;
        end else begin
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            wb_halt_q     <= wb_halt_d;
            wb_dst_reg_q  <= wb_dst_reg_d;
            wb_alu_q      <= wb_alu_d;
            wb_mem_q      <= wb_mem_d;
            halted_q      <= halted_d;
            retire_cnt_q  <= retire_cnt_d;
        end
    end

    assign DstReg       = wb_dst_reg_q;
    assign DstData      = wb_memtoreg_q ? wb_mem_q : wb_alu_q;
    assign WriteReg     = wb_valid_q & wb_regwrite_q & ~wb_halt_q & ~halted_q
                        & (wb_dst_reg_q != '0);
    assign halted       = halted_q;
    assign retire_count = retire_cnt_q;

    always_comb begin
        bypass_data1 = rf_data1;
        bypass_data2 = rf_data2;
        if (SrcReg1 == '0) begin
            bypass_data1 = '0;
        end else if (WriteReg && (DstReg == SrcReg1)) begin
            bypass_data1 = DstData;
        end
        if (SrcReg2 == '0) begin
            bypass_data2 = '0;
        end else if (WriteReg && (DstReg == SrcReg2)) begin
            bypass_data2 = DstData;
        end
    end

endmodule

// File: tb/tb_regfile_wb_stage.sv
module tb_regfile_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        in_valid, in_regwrite, in_memtoreg, in_halt;
    logic [3:0]  in_dst_reg, SrcReg1, SrcReg2;
    logic [15:0] in_alu_result, in_mem_data, rf_data1, rf_data2;
    logic [3:0]  DstReg;
    logic [15:0] DstData, bypass_data1, bypass_data2, retire_count;
    logic        WriteReg, halted;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    regfile_wb_stage #(.DATA_W(16), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .in_halt(in_halt), .in_dst_reg(in_dst_reg), .in_alu_result(in_alu_result),
        .in_mem_data(in_mem_data), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .DstReg(DstReg), .DstData(DstData),
        .WriteReg(WriteReg), .bypass_data1(bypass_data1), .bypass_data2(bypass_data2),
        .halted(halted), .retire_count(retire_count)
    );

    // Reference model: the instruction sitting in WB plus architectural counters.
    typedef struct {
        bit        v, rw, m2r, h;
        bit [3:0]  dst;
        bit [15:0] alu, mem;
    } instr_t;
    instr_t      m_wb;
    bit          m_halted;
    int unsigned m_cnt;

    task automatic model_edge();
        instr_t nxt;
        bit     retire;
        if (rst) begin
            m_wb     = '{0, 0, 0, 0, 4'd0, 16'd0, 16'd0};
            m_halted = 0;
            m_cnt    = 0;
            return;
        end
        retire = m_wb.v && !stall && !flush && !m_halted;
        nxt = m_wb;
        if (flush)                            nxt.v = 0;
        else if (m_halted || (m_wb.v && m_wb.h)) nxt.v = 0;
        else if (!stall)
            nxt = '{in_valid, in_regwrite, in_memtoreg, in_halt, in_dst_reg, in_alu_result, in_mem_data};
        if (retire) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_wb.h) m_halted = 1;
        end
        m_wb = nxt;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ewr, input logic [3:0] edst,
                             input logic [15:0] edata, input logic [15:0] eb1,
                             input logic [15:0] eb2, input logic [15:0] ecnt, input logic ehalt);
        chk({tag, ".WriteReg"},     {15'd0, WriteReg}, {15'd0, ewr});
        chk({tag, ".DstReg"},       {12'd0, DstReg},   {12'd0, edst});
        chk({tag, ".DstData"},      DstData,           edata);
        chk({tag, ".bypass_data1"}, bypass_data1,      eb1);
        chk({tag, ".bypass_data2"}, bypass_data2,      eb2);
        chk({tag, ".retire_count"}, retire_count,      ecnt);
        chk({tag, ".halted"},       {15'd0, halted},   {15'd0, ehalt});
    endtask

    task automatic check_model(input string tag);
        bit        wr;
        bit [15:0] data, b1, b2;
        wr   = m_wb.v && m_wb.rw && !m_wb.h && !m_halted && (m_wb.dst != 0);
        data = m_wb.m2r ? m_wb.mem : m_wb.alu;
        b1   = (SrcReg1 == 0) ? 16'd0 : (wr && m_wb.dst == SrcReg1) ? data : rf_data1;
        b2   = (SrcReg2 == 0) ? 16'd0 : (wr && m_wb.dst == SrcReg2) ? data : rf_data2;
        check_all(tag, wr, m_wb.dst, data, b1, b2, m_cnt[15:0], m_halted);
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic h,
                         input logic [3:0] dst, input logic [15:0] alu, input logic [15:0] mem);
        in_valid = v; in_regwrite = rw; in_memtoreg = m2r; in_halt = h;
        in_dst_reg = dst; in_alu_result = alu; in_mem_data = mem;
    endtask

    typedef struct {
        logic        stall, flush, valid, regw, m2r, halt;
        logic [3:0]  dst;
        logic [15:0] alu, mem;
        logic [3:0]  s1, s2;
        logic [15:0] r1, r2;
        logic        ewr;
        logic [3:0]  edst;
        logic [15:0] edata, eb1, eb2, ecnt;
        logic        ehalted;
    } vec_t;
    vec_t vecs[9];

    initial begin
        vecs[0] = '{0,0,1,1,0,0,4'd3,16'h1234,16'h0000,4'd3,4'd4,16'hBEEF,16'h4444, 1,4'd3,16'h1234,16'h1234,16'h4444,16'd0,0};
        vecs[1] = '{0,0,1,1,1,0,4'd0,16'h1111,16'hA5A5,4'd3,4'd0,16'hBEEF,16'hFFFF, 0,4'd0,16'hA5A5,16'hBEEF,16'h0000,16'd1,0};
        vecs[2] = '{0,0,1,1,0,0,4'd5,16'h5555,16'h0000,4'd5,4'd5,16'h0000,16'h0101, 1,4'd5,16'h5555,16'h5555,16'h5555,16'd2,0};
        vecs[3] = '{1,0,1,1,0,0,4'd6,16'h6666,16'h0000,4'd5,4'd6,16'h0001,16'h2222, 1,4'd5,16'h5555,16'h5555,16'h2222,16'd2,0};
        vecs[4] = vecs[3];
        vecs[5] = vecs[3];
        vecs[6] = '{0,0,1,1,0,0,4'd6,16'h6666,16'h0000,4'd6,4'd5,16'h0000,16'h2222, 1,4'd6,16'h6666,16'h6666,16'h2222,16'd3,0};
        vecs[7] = '{1,1,1,1,0,0,4'd7,16'h7777,16'h0000,4'd6,4'd0,16'h00AB,16'h1234, 0,4'd6,16'h6666,16'h00AB,16'h0000,16'd3,0};
        vecs[8] = '{0,0,0,1,0,0,4'd8,16'h8888,16'h0000,4'd8,4'd1,16'h0C0C,16'h0001, 0,4'd8,16'h8888,16'h0C0C,16'h0001,16'd3,0};

        // Reset with a live instruction on the inputs; state must still clear.
        rst = 1; stall = 0; flush = 0;
        drive(1, 1, 0, 0, 4'd9, 16'hFFFF, 16'hEEEE);
        SrcReg1 = 4'd9; SrcReg2 = 4'd0; rf_data1 = 16'h0909; rf_data2 = 16'h1111;
        cyc(); cyc();
        check_all("reset", 0, 4'd0, 16'h0000, 16'h0909, 16'h0000, 16'd0, 0);
        rst = 0;

        // Directed table: basic write, $0 suppression, stall hold, flush bubble.
        for (int i = 0; i < 9; i++) begin
            stall = vecs[i].stall; flush = vecs[i].flush;
            drive(vecs[i].valid, vecs[i].regw, vecs[i].m2r, vecs[i].halt,
                  vecs[i].dst, vecs[i].alu, vecs[i].mem);
            SrcReg1 = vecs[i].s1; SrcReg2 = vecs[i].s2;
            rf_data1 = vecs[i].r1; rf_data2 = vecs[i].r2;
            cyc();
            check_all($sformatf("vec%0d", i), vecs[i].ewr, vecs[i].edst, vecs[i].edata,
                      vecs[i].eb1, vecs[i].eb2, vecs[i].ecnt, vecs[i].ehalted);
        end

        // HLT after four ALU ops, then a write that must be ignored, then reset.
        rst = 1; stall = 0; flush = 0; drive(0, 0, 0, 0, 4'd0, 16'd0, 16'd0);
        SrcReg1 = 4'd7; SrcReg2 = 4'd0; rf_data1 = 16'h0707; rf_data2 = 16'h0;
        cyc();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 4'(i + 1), 16'(16'h100 + i), 16'd0);
            cyc();
        end
        drive(1, 0, 0, 1, 4'd0, 16'd0, 16'd0);
        cyc();
        check_all("hlt_in_wb", 0, 4'd0, 16'h0000, 16'h0707, 16'h0000, 16'd4, 0);
        drive(1, 1, 0, 0, 4'd7, 16'h7777, 16'd0);
        cyc();
        check_all("hlt_retired", 0, 4'd0, 16'h0000, 16'h0707, 16'h0000, 16'd5, 1);
        cyc();
        chk("after_halt.WriteReg", {15'd0, WriteReg}, 16'd0);
        chk("after_halt.retire_count", retire_count, 16'd5);
        chk("after_halt.bypass_data1", bypass_data1, 16'h0707);
        rst = 1;
        cyc();
        rst = 0;
        check_all("halt_reset", 0, 4'd0, 16'h0000, 16'h0707, 16'h0000, 16'd0, 0);

        // Randomized run against the reference model.
        for (int n = 0; n < 1500; n++) begin
            rst   = ($urandom_range(63) == 0);
            stall = ($urandom_range(3) == 0);
            flush = ($urandom_range(7) == 0);
            drive($urandom_range(1), $urandom_range(1), $urandom_range(1),
                  ($urandom_range(31) == 0), 4'($urandom), 16'($urandom), 16'($urandom));
            SrcReg1 = $urandom_range(1) ? in_dst_reg : 4'($urandom);
            SrcReg2 = $urandom_range(1) ? m_wb.dst : 4'($urandom);
            rf_data1 = 16'($urandom); rf_data2 = 16'($urandom);
            cyc();
            check_model($sformatf("rand%0d", n));
        end

        // Saturation: 65535 edges of back-to-back valid instructions leave 16'hFFFE.
        rst = 1; stall = 0; flush = 0; drive(0, 0, 0, 0, 4'd0, 16'd0, 16'd0);
        cyc();
        rst = 0;
        drive(1, 0, 0, 0, 4'd2, 16'h0002, 16'd0);
        for (int n = 0; n < 65535; n++) cyc();
        chk("sat.start", retire_count, 16'hFFFE);
        for (int n = 0; n < 3; n++) begin
            cyc();
            chk($sformatf("sat.retire%0d", n), retire_count, 16'hFFFF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
